// File: rtl/mbe_pkg.sv
// mbe_pkg: shared definitions for the iterative radix-4 modified-Booth multiplier.
//   state_t      : controller states (IDLE/BUSY/DONE)
//   BOOTH_*      : bit positions inside a 3-bit Booth digit window
//   num_digits() : Booth digit count for an operand width, rounded up to a
//                  multiple of the digits retired per cycle
package mbe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Window layout {b2, b1, b0} = {x[2i+1], x[2i], x[2i-1]}
    localparam int unsigned BOOTH_WIN = 3;
    localparam int unsigned BOOTH_B0  = 0;
    localparam int unsigned BOOTH_B1  = 1;
    localparam int unsigned BOOTH_B2  = 2;

    // Unsigned operands need one extra digit: the multiplier is treated as
    // zero-extended by two bits so its top digit never reads as negative.
    function automatic int unsigned num_digits(input int unsigned width,
                                               input int unsigned dpc,
                                               input bit          signed_mode);
        int unsigned n;
        n = signed_mode ? (width / 2) : (width / 2 + 1);
        return ((n + dpc - 1) / dpc) * dpc;
    endfunction

endpackage

// File: rtl/mbe_digit.sv
// mbe_digit: one radix-4 modified-Booth digit.
//   win   in  3        digit window {x[2i+1], x[2i], x[2i-1]}
//   y_ext in  WIDTH+2  multiplicand, sign- or zero-extended by the caller
//   pp    out WIDTH+2  two's-complement partial product in {-2y..+2y}
// single/double/neg are decoded internally from the window.
module mbe_digit
    import mbe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [BOOTH_WIN-1:0] win,
    input  logic [WIDTH+1:0]     y_ext,
    output logic [WIDTH+1:0]     pp
);

    logic             single;
    logic             dbl;
    logic             neg;
    logic [WIDTH+1:0] mag;

    always_comb begin
        single = win[BOOTH_B1] ^ win[BOOTH_B0];
        dbl    = ( win[BOOTH_B2] & ~win[BOOTH_B1] & ~win[BOOTH_B0]) |
                 (~win[BOOTH_B2] &  win[BOOTH_B1] &  win[BOOTH_B0]);
        neg    = win[BOOTH_B2];

        mag = '0;
        if (single) begin
            mag = y_ext;
        end else if (dbl) begin
            mag = y_ext << 1;
        end

        // Digit 111 has neg set but zero magnitude; gate neg so it stays 0.
        pp = (neg && (single || dbl)) ? (~mag + 1'b1) : mag;
    end

endmodule

// File: rtl/mbe_mult_seq.sv
// mbe_mult_seq: iterative radix-4 modified-Booth multiplier.
// Retires DPC Booth digits per cycle and returns a 2*WIDTH-bit product.
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous, active-high
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        high in IDLE
//   x          in   WIDTH    multiplier (Booth-recoded)
//   y          in   WIDTH    multiplicand
//   tc         in   1        1 = signed, 0 = unsigned (only with MBE_SIGN_SEL_EN)
//   out_valid  out  1        high in DONE
//   out_ready  in   1        consumer accepts product
//   p          out  2*WIDTH  product, stable while out_valid & ~out_ready
// Optional feature macro: MBE_SIGN_SEL_EN (adds tc and the unsigned extra digit).
// Without it the block is signed-only.
module mbe_mult_seq
    import mbe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DPC   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
`ifdef MBE_SIGN_SEL_EN
    input  logic                 tc,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int unsigned NS   = num_digits(WIDTH, DPC, 1'b1);
`ifdef MBE_SIGN_SEL_EN
    localparam int unsigned NMAX = num_digits(WIDTH, DPC, 1'b0);
`else
    localparam int unsigned NMAX = NS;
`endif
    localparam int unsigned CS   = NS / DPC;
    localparam int unsigned CMAX = NMAX / DPC;
    localparam int unsigned CNTW = $clog2(CMAX + 1);
    // Two spare bits above the last digit keep the extension width non-zero.
    localparam int unsigned XW   = 2 * NMAX + 3;
    localparam int unsigned AW   = 2 * WIDTH;

    state_t            state;
    logic [XW-1:0]     xr;
    logic [WIDTH+1:0]  yr;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     sum;
    logic [CNTW-1:0]   cnt;
    logic [WIDTH+1:0]  pp [DPC];
    logic              sgn;
    logic              last;

`ifdef MBE_SIGN_SEL_EN
    logic              tc_q;
    assign sgn  = tc;
    assign last = tc_q ? (cnt == CNTW'(CS - 1)) : (cnt == CNTW'(CMAX - 1));
`else
    assign sgn  = 1'b1;
    assign last = (cnt == CNTW'(CS - 1));
`endif

    for (genvar g = 0; g < DPC; g++) begin : g_digit
        mbe_digit #(.WIDTH(WIDTH)) u_digit (
            .win   (xr[2*g+2 -: 3]),
            .y_ext (yr),
            .pp    (pp[g])
        );
    end

    // The product always fits in 2*WIDTH bits, and the guard bits of a
    // 2*WIDTH+2 accumulator never feed back into the low bits, so the sum is
    // kept modulo 2^(2*WIDTH).
    always_comb begin
        sum = acc;
        for (int unsigned j = 0; j < DPC; j++) begin
            sum = sum + ({{(AW-WIDTH-2){pp[j][WIDTH+1]}}, pp[j]}
                         << (2 * (32'(cnt) * DPC + j)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            xr    <= '0;
            yr    <= '0;
            acc   <= '0;
            cnt   <= '0;
`ifdef MBE_SIGN_SEL_EN
            tc_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= BUSY;
                        xr    <= {{(XW-1-WIDTH){x[WIDTH-1] & sgn}}, x, 1'b0};
                        yr    <= {{2{y[WIDTH-1] & sgn}}, y};
                        acc   <= '0;
                        cnt   <= '0;
`ifdef MBE_SIGN_SEL_EN
                        tc_q  <= tc;
`endif
                    end
                end
                BUSY: begin
                    acc <= sum;
                    xr  <= xr >> (2 * DPC);
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign p         = acc;

endmodule

// File: tb/tb_mbe_mult_seq.sv
module tb_mbe_mult_seq;

    localparam int unsigned WA = 8;
    localparam int unsigned DA = 1;
    localparam int unsigned WB = 16;
    localparam int unsigned DB = 2;

    typedef struct {
        logic [31:0] p;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_a, rst_b;
    logic              iva, ira, ova, ora;
    logic [WA-1:0]     xa, ya;
    logic [2*WA-1:0]   pa;
    logic              ivb, irb, ovb, orb;
    logic [WB-1:0]     xb, yb;
    logic [2*WB-1:0]   pb;
`ifdef MBE_SIGN_SEL_EN
    logic              tca, tcb;
`endif

    mbe_mult_seq #(.WIDTH(WA), .DPC(DA)) dut_a (
        .clk(clk), .reset(rst_a), .in_valid(iva), .in_ready(ira),
        .x(xa), .y(ya),
`ifdef MBE_SIGN_SEL_EN
        .tc(tca),
`endif
        .out_valid(ova), .out_ready(ora), .p(pa)
    );

    mbe_mult_seq #(.WIDTH(WB), .DPC(DB)) dut_b (
        .clk(clk), .reset(rst_b), .in_valid(ivb), .in_ready(irb),
        .x(xb), .y(yb),
`ifdef MBE_SIGN_SEL_EN
        .tc(tcb),
`endif
        .out_valid(ovb), .out_ready(orb), .p(pb)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    bit   b_bp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer product of the operands as interpreted by mode.
    function automatic logic [31:0] ref_prod(input int unsigned w, input logic [15:0] x,
                                             input logic [15:0] y, input bit sg);
        longint m, a, b;
        m = longint'(1) << w;
        a = longint'(x) % m;
        b = longint'(y) % m;
        if (sg && a >= m / 2) a -= m;
        if (sg && b >= m / 2) b -= m;
        return 32'((a * b) & ((longint'(1) << (2 * w)) - 1));
    endfunction

    function automatic int ref_lat(input int unsigned w, input int unsigned dpc, input bit sg);
        int unsigned n;
        n = sg ? w / 2 : w / 2 + 1;
        n = ((n + dpc - 1) / dpc) * dpc;
        return int'(n / dpc);
    endfunction

    // Monitors: latency counted in rising edges from the accept edge to the
    // edge that raises out_valid; product checked on each output handshake.
    int lat_a, lat_b;
    bit trk_a, seen_a, trk_b, seen_b;

    always @(negedge clk) begin
        if (rst_a) begin
            trk_a = 0; seen_a = 0;
        end else begin
            if (trk_a) lat_a++;
            if (ova && !seen_a) begin
                seen_a = 1;
                trk_a  = 0;
                check("A queue non-empty at out_valid", 64'(qa.size() > 0), 64'd1);
                if (qa.size() > 0) check("A latency", 64'(lat_a), 64'(qa[0].lat));
            end
            if (ova && ora) begin
                seen_a = 0;
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    check("A product", 64'(pa), 64'(ea.p));
                end
            end
            if (iva && ira) begin trk_a = 1; lat_a = -1; end
        end
    end

    always @(negedge clk) begin
        if (rst_b) begin
            trk_b = 0; seen_b = 0;
        end else begin
            if (trk_b) lat_b++;
            if (ovb && !seen_b) begin
                seen_b = 1;
                trk_b  = 0;
                check("B queue non-empty at out_valid", 64'(qb.size() > 0), 64'd1);
                if (qb.size() > 0) check("B latency", 64'(lat_b), 64'(qb[0].lat));
            end
            if (ovb && orb) begin
                seen_b = 0;
                if (qb.size() > 0) begin
                    eb = qb.pop_front();
                    check("B product", 64'(pb), 64'(eb.p));
                end
            end
            if (ivb && irb) begin trk_b = 1; lat_b = -1; end
        end
    end

    always @(posedge clk) begin
        if (b_bp) begin
            #1;
            orb = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic drive_a(input logic [WA-1:0] x, input logic [WA-1:0] y, input bit t);
        int n = 0;
        @(posedge clk); #1;
        iva = 1'b1; xa = x; ya = y;
`ifdef MBE_SIGN_SEL_EN
        tca = t;
`endif
        @(negedge clk);
        while (!ira && n < 100) begin n++; @(negedge clk); end
        if (!ira) check("A accept timeout", 64'(ira), 64'd1);
        else qa.push_back('{ref_prod(WA, 16'(x), 16'(y), t), ref_lat(WA, DA, t)});
        @(posedge clk); #1;
        iva = 1'b0;
    endtask

    task automatic drive_b(input logic [WB-1:0] x, input logic [WB-1:0] y, input bit t);
        int n = 0;
        @(posedge clk); #1;
        ivb = 1'b1; xb = x; yb = y;
`ifdef MBE_SIGN_SEL_EN
        tcb = t;
`endif
        @(negedge clk);
        while (!irb && n < 500) begin n++; @(negedge clk); end
        if (!irb) check("B accept timeout", 64'(irb), 64'd1);
        else qb.push_back('{ref_prod(WB, x, y, t), ref_lat(WB, DB, t)});
        @(posedge clk); #1;
        ivb = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        while ((qa.size() > 0 || !ira) && n < 300) begin n++; @(negedge clk); end
        check("A drain", 64'(qa.size()), 64'd0);
    endtask

    task automatic drain_b();
        int n = 0;
        while ((qb.size() > 0 || !irb) && n < 2000) begin n++; @(negedge clk); end
        check("B drain", 64'(qb.size()), 64'd0);
    endtask

    task automatic random_a();
        bit t;
        for (int i = 0; i < 200; i++) begin
            t = 1'b1;
`ifdef MBE_SIGN_SEL_EN
            t = 1'($urandom_range(0, 1));
`endif
            drive_a(WA'($urandom), WA'($urandom), t);
        end
        drain_a();
    endtask

    task automatic random_b();
        bit t;
        b_bp = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            t = 1'b1;
`ifdef MBE_SIGN_SEL_EN
            t = 1'($urandom_range(0, 1));
`endif
            drive_b(WB'($urandom), WB'($urandom), t);
        end
        drain_b();
        b_bp = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        iva = 1'b0; ivb = 1'b0; ora = 1'b1; orb = 1'b1;
        xa = '0; ya = '0; xb = '0; yb = '0;
`ifdef MBE_SIGN_SEL_EN
        tca = 1'b1; tcb = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(ira), 64'd1);
        check("reset out_valid", 64'(ova), 64'd0);
        check("reset p", 64'(pa), 64'd0);
        check("reset B p", 64'(pb), 64'd0);
        rst_a = 1'b0; rst_b = 1'b0;

        // Directed signed cases
        drive_a(8'd3, 8'd5, 1'b1);
        drain_a();
        drive_a(8'h80, 8'h80, 1'b1);
        drain_a();
        drive_a(8'hFF, 8'h7F, 1'b1);
        drain_a();
        check("ref -128*-128", 64'(ref_prod(WA, 16'h0080, 16'h0080, 1'b1)), 64'h4000);
`ifdef MBE_SIGN_SEL_EN
        drive_a(8'hFF, 8'hFF, 1'b0);
        drain_a();
        drive_a(8'hFF, 8'hFF, 1'b1);
        drain_a();
`endif

        // Back-pressure in DONE: outputs frozen, new operands ignored
        ora = 1'b0;
        drive_a(8'd10, 8'hFD, 1'b1);
        begin
            int n = 0;
            while (!ova && n < 50) begin n++; @(negedge clk); end
        end
        check("hold reached DONE", 64'(ova), 64'd1);
        iva = 1'b1; xa = 8'd55; ya = 8'd9;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hold out_valid", 64'(ova), 64'd1);
            check("hold p", 64'(pa), 64'hFFE2);
            check("hold in_ready", 64'(ira), 64'd0);
        end
        @(posedge clk); #1;
        iva = 1'b0; ora = 1'b1;
        @(posedge clk); #1;
        check("release in_ready", 64'(ira), 64'd1);
        check("release out_valid", 64'(ova), 64'd0);

        // Reset two cycles into BUSY
        drive_a(8'd100, 8'd100, 1'b1);
        @(posedge clk); #1;
        rst_a = 1'b1;
        #1;
        check("mid-reset in_ready", 64'(ira), 64'd1);
        check("mid-reset out_valid", 64'(ova), 64'd0);
        check("mid-reset p", 64'(pa), 64'd0);
        qa.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        check("post-reset out_valid", 64'(ova), 64'd0);
        drive_a(8'd7, 8'hFA, 1'b1);
        drain_a();

        fork
            random_a();
            random_b();
        join

        check("A scoreboard empty", 64'(qa.size()), 64'd0);
        check("B scoreboard empty", 64'(qb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
